// File: rtl/cache_flush_ctrl_pkg.sv
// Shared definitions for the cache flush sequencer: geometry, status-bit
// positions and the flush FSM encoding.
package cache_pkg;

  localparam int LINES = 128;
  localparam int IDXW  = 7;
  localparam int CNTW  = 8;

  localparam int ST_VALID = 1;
  localparam int ST_DIRTY = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WB    = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cache_flush_ctrl_if.sv
// Signal bundle between the flush sequencer (master) and the cache top-level,
// status mux and writeback path (slave).
interface cache_flush_ctrl_if;
  import cache_pkg::*;

  logic            flush_start;
  logic            flush_busy;
  logic            flush_done;
  logic [IDXW-1:0] sel;
  logic [1:0]      line_state;
  // wb_req is valid, wb_ack is ready: a writeback transfers at the first rising
  // edge where both are high; wb_req and wb_idx stay stable until then.
  logic            wb_req;
  logic [IDXW-1:0] wb_idx;
  logic            wb_ack;
  logic            clr_dirty;
  logic [IDXW-1:0] clr_idx;
  logic [CNTW-1:0] wb_count;

  modport master (
    input  flush_start, line_state, wb_ack,
    output flush_busy, flush_done, sel, wb_req, wb_idx, clr_dirty, clr_idx, wb_count
  );

  modport slave (
    output flush_start, line_state, wb_ack,
    input  flush_busy, flush_done, sel, wb_req, wb_idx, clr_dirty, clr_idx, wb_count
  );

endinterface

// File: rtl/mux128to1.sv
// 128-way line-status selector; lives outside the flush sequencer.
module mux128to1 #(
  parameter int w = 2
) (
  input  logic [128*w-1:0] in_bus,
  input  logic [6:0]       sel,
  output logic [w-1:0]     out
);

  assign out = in_bus[int'(sel)*w +: w];

endmodule

// File: rtl/cache_flush_ctrl.sv
// Full-cache flush sequencer: scans every line, writes back valid+dirty lines
// through a req/ack handshake and strobes a dirty-clear after each one.
module cache_flush_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_flush_ctrl_if.master bus,
  output state_t             state_dbg
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            req_q, req_d;
  logic            clr_q, clr_d;
  logic            line_wb;

  assign line_wb = bus.line_state[ST_VALID] && bus.line_state[ST_DIRTY];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_start) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (line_wb) begin
          state_d = WB;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      WB: begin
        if (bus.wb_ack) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = CHECK;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered yet
  // stay aligned with the state they belong to.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    req_d  = (state_d == WB);
    clr_d  = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.sel        = idx_q;
  assign bus.wb_idx     = idx_q;
  assign bus.clr_idx    = idx_q;
  assign bus.wb_count   = cnt_q;
  assign bus.flush_busy = busy_q;
  assign bus.flush_done = done_q;
  assign bus.wb_req     = req_q;
  assign bus.clr_dirty  = clr_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Bench for cache_flush_ctrl: directed scenario table, reset-in-writeback
// sequence and randomized status/ack-delay flushes against a scan model.
module tb_cache_flush_ctrl;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] status;
  state_t       state_dbg;

  always #5 clk = ~clk;

  cache_flush_ctrl_if bus_if();

  mux128to1 #(.w(2)) u_mux (
    .in_bus (status),
    .sel    (bus_if.sel),
    .out    (bus_if.line_state)
  );

  cache_flush_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [IDXW-1:0] exp_q[$];
  logic [IDXW-1:0] clr_q[$];
  int              del_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] set_line(input logic [255:0] s, input int i, input logic [1:0] v);
    logic [255:0] r;
    r = s;
    r[2*i +: 2] = v;
    return r;
  endfunction

  // mode 0: ack after fixed dly wait cycles, 1: random per-request delay,
  // 2: ack tied high. exp_cnt_c/exp_lat_c < 0 means use the scan model.
  task automatic run_flush(input string nm, input logic [255:0] st, input int mode, input int dly,
                           input int mid, input int exp_cnt_c, input int exp_lat_c);
    int exp_cnt, exp_lat, k, done_cnt, done_k, wait_ctr, cur_dly, clr_seen, req_seen;
    logic prev_req;
    logic [IDXW-1:0] held;
    status = st;
    exp_q.delete();
    clr_q.delete();
    del_q.delete();
    for (int i = 0; i < LINES; i++) begin
      if (st[2*i+1] && st[2*i]) begin
        exp_q.push_back(IDXW'(i));
        clr_q.push_back(IDXW'(i));
        del_q.push_back(mode == 1 ? int'($urandom_range(0, 3)) : (mode == 2 ? 0 : dly));
      end
    end
    exp_cnt = exp_q.size();
    exp_lat = LINES;
    foreach (del_q[j]) exp_lat += del_q[j] + 2;
    if (exp_cnt_c >= 0) exp_cnt = exp_cnt_c;
    if (exp_lat_c >= 0) exp_lat = exp_lat_c;

    bus_if.wb_ack      = (mode == 2);
    bus_if.flush_start = 1'b1;
    @(posedge clk); #1;
    bus_if.flush_start = 1'b0;
    chk({nm, "_first_sel"}, bus_if.sel, 0);
    chk({nm, "_first_busy"}, bus_if.flush_busy, 1);

    k = 0; done_cnt = 0; done_k = -1; wait_ctr = 0; cur_dly = 0;
    clr_seen = 0; req_seen = 0; prev_req = 1'b0; held = '0;
    while (k <= exp_lat + 40) begin
      if (bus_if.flush_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_k = k;
          chk({nm, "_busy_in_done"}, bus_if.flush_busy, 1);
          chk({nm, "_count_at_done"}, bus_if.wb_count, exp_cnt);
        end
      end
      if (bus_if.wb_req) begin
        if (!prev_req) begin
          req_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_wb_idx: got unexpected wb_req idx %0d, expected none", nm, bus_if.wb_idx);
          end else begin
            chk({nm, "_wb_idx"}, bus_if.wb_idx, exp_q.pop_front());
          end
          held     = bus_if.wb_idx;
          wait_ctr = 0;
          cur_dly  = (del_q.size() > 0) ? del_q.pop_front() : 0;
        end else begin
          chk({nm, "_wb_idx_stable"}, bus_if.wb_idx, held);
        end
        if (mode != 2) bus_if.wb_ack = (wait_ctr == cur_dly);
        wait_ctr++;
      end else if (mode != 2) begin
        bus_if.wb_ack = 1'b0;
      end
      if (bus_if.clr_dirty) begin
        clr_seen++;
        if (clr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL %s_clr_idx: got unexpected clr_dirty idx %0d, expected none", nm, bus_if.clr_idx);
        end else begin
          chk({nm, "_clr_idx"}, bus_if.clr_idx, clr_q.pop_front());
        end
      end
      bus_if.flush_start = (mid != 0 && k == mid);
      prev_req = bus_if.wb_req;
      if (done_cnt > 0 && k >= done_k + 5) break;
      @(posedge clk); #1;
      k++;
    end
    bus_if.wb_ack      = 1'b0;
    bus_if.flush_start = 1'b0;
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_latency"}, done_k, exp_lat);
    chk({nm, "_wb_reqs"}, req_seen, exp_cnt);
    chk({nm, "_clears"}, clr_seen, exp_cnt);
    chk({nm, "_count_held"}, bus_if.wb_count, exp_cnt);
    chk({nm, "_idle_busy"}, bus_if.flush_busy, 0);
    chk({nm, "_idle_state"}, state_dbg, IDLE);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [255:0] st;
    int           mode;
    int           dly;
    int           mid;
    int           exp_cnt;
    int           exp_lat;
  } vec_t;

  vec_t tab[5];

  initial begin
    logic [255:0] s;
    int clr_during_rst;

    tab[0] = '{st: {128{2'b10}}, mode: 0, dly: 0, mid: 0, exp_cnt: 0, exp_lat: 128};
    s = {128{2'b10}};
    s = set_line(s, 0, 2'b11);
    s = set_line(s, 5, 2'b11);
    s = set_line(s, 127, 2'b11);
    tab[1] = '{st: s, mode: 0, dly: 1, mid: 0, exp_cnt: 3, exp_lat: 137};
    tab[2] = '{st: set_line({128{2'b10}}, 64, 2'b11), mode: 0, dly: 10, mid: 0, exp_cnt: 1, exp_lat: 140};
    tab[3] = '{st: set_line({128{2'b10}}, 3, 2'b01), mode: 0, dly: 0, mid: 50, exp_cnt: 0, exp_lat: 128};
    tab[4] = '{st: {128{2'b11}}, mode: 2, dly: 0, mid: 0, exp_cnt: 128, exp_lat: 384};

    rst = 1'b1;
    status = '0;
    bus_if.flush_start = 1'b0;
    bus_if.wb_ack      = 1'b0;
    #3;
    chk("rst_sel", bus_if.sel, 0);
    chk("rst_wb_req", bus_if.wb_req, 0);
    chk("rst_busy", bus_if.flush_busy, 0);
    chk("rst_done", bus_if.flush_done, 0);
    chk("rst_clr", bus_if.clr_dirty, 0);
    chk("rst_count", bus_if.wb_count, 0);
    chk("rst_state", state_dbg, IDLE);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      run_flush($sformatf("tab%0d", t), tab[t].st, tab[t].mode, tab[t].dly, tab[t].mid,
                tab[t].exp_cnt, tab[t].exp_lat);
    end

    // reset while a writeback is pending at idx 10
    status = set_line({128{2'b10}}, 10, 2'b11);
    bus_if.flush_start = 1'b1;
    @(posedge clk); #1;
    bus_if.flush_start = 1'b0;
    for (int c = 0; c < 200 && !bus_if.wb_req; c++) begin
      @(posedge clk); #1;
    end
    chk("t5_wb_req_reached", bus_if.wb_req, 1);
    chk("t5_wb_idx", bus_if.wb_idx, 10);
    chk("t5_sel", bus_if.sel, 10);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_async_wb_req", bus_if.wb_req, 0);
    chk("t5_async_busy", bus_if.flush_busy, 0);
    chk("t5_async_sel", bus_if.sel, 0);
    chk("t5_async_clr", bus_if.clr_dirty, 0);
    chk("t5_async_count", bus_if.wb_count, 0);
    chk("t5_async_state", state_dbg, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_during_rst = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus_if.clr_dirty) clr_during_rst++;
      @(posedge clk); #1;
    end
    chk("t5_no_clear", clr_during_rst, 0);
    run_flush("t5_restart", status, 0, 0, 0, 1, 130);

    // randomized flushes checked against the scan model
    for (int r = 0; r < 4; r++) begin
      s = '0;
      for (int i = 0; i < LINES; i++) s[2*i +: 2] = 2'($urandom_range(0, 3));
      run_flush($sformatf("rand%0d", r), s, 1, 0, 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
